// File: rtl/vga_frame_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_capture_if
// Purpose  : Video-in / video-memory-write bundle for vga_frame_capture.
//            The source (master) drives sync and colour. The capture block
//            (slave) drives the memory write port and the status flags.
// Revision : 1.0  initial release
// ============================================================================
interface vga_frame_capture_if #(
  parameter int WIN_BITS = 8
);
  logic                      hsync;
  logic                      vsync;
  logic [2:0]                color;
  logic                      write_enable;
  logic [2*WIN_BITS-1:0]     write_address;
  logic [2:0]                write_data;
  logic                      frame_done;
  logic                      locked;
  logic                      error;

  modport master (
    output hsync, vsync, color,
    input  write_enable, write_address, write_data, frame_done, locked, error
  );

  modport slave (
    input  hsync, vsync, color,
    output write_enable, write_address, write_data, frame_done, locked, error
  );
endinterface
`default_nettype wire

// File: rtl/vga_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_capture
// Purpose  : Receiving end of a VGA link whose pixel rate is clk/2.
//            - Recovers the pixel and line position from HSync and VSync.
//            - Writes a centred window of 2^WIN_BITS x 2^WIN_BITS pixels
//              into video memory, one write per pixel.
//            - Flags frame completion and checks raster timing lock.
// Revision : 1.0  initial release
// ============================================================================
module vga_frame_capture #(
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_TOTAL   = 800,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 29,
  parameter int V_TOTAL   = 521,
  parameter int WIN_X0    = 192,
  parameter int WIN_Y0    = 112,
  parameter int WIN_BITS  = 8,
  parameter int LINE_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_frame_capture_if.slave   vid
);

  localparam int PIX_BITS = $clog2(H_TOTAL);
  localparam int WIN_SIZE = 1 << WIN_BITS;

  localparam logic [PIX_BITS-1:0]  PIX_LAST    = PIX_BITS'(H_TOTAL - 1);
  localparam logic [PIX_BITS-1:0]  X_FIRST     = PIX_BITS'(H_SYNC + H_BACK + WIN_X0);
  localparam logic [PIX_BITS-1:0]  X_LAST      = PIX_BITS'(H_SYNC + H_BACK + WIN_X0 + WIN_SIZE - 1);
  localparam logic [LINE_BITS-1:0] Y_FIRST     = LINE_BITS'(V_SYNC + V_BACK + WIN_Y0);
  localparam logic [LINE_BITS-1:0] Y_LAST      = LINE_BITS'(V_SYNC + V_BACK + WIN_Y0 + WIN_SIZE - 1);
  localparam logic [LINE_BITS-1:0] LINES_FRAME = LINE_BITS'(V_TOTAL);
  localparam logic [LINE_BITS-1:0] LINE_MAX    = {LINE_BITS{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } state_t;

  state_t state;

  // Input synchronisers. Stage [0] and [1] form the 2-flop synchroniser;
  // stage [2] holds the previous synced value for edge detection.
  logic [2:0] hs_pipe;
  logic [2:0] vs_pipe;
  logic [2:0] color_s1;
  logic [2:0] color_s2;

  // Raster position. phase=0 marks a cycle on which pixel 'pix' is sampled.
  logic [PIX_BITS-1:0]  pix;
  logic                 phase;
  logic [LINE_BITS-1:0] line;

  // Next-state and decode terms
  logic                 hs_fall;
  logic                 vs_fall;
  logic                 sample;
  logic                 hs_slip;
  logic [PIX_BITS-1:0]  pix_cur;
  logic [PIX_BITS-1:0]  pix_next;
  logic                 phase_next;
  logic [LINE_BITS-1:0] line_inc;
  logic [LINE_BITS-1:0] line_next;
  logic                 in_window;
  logic                 do_write;
  logic [WIN_BITS-1:0]  row_off;
  logic [WIN_BITS-1:0]  col_off;

  // Bring async syncs and colour into the clock domain; idle level of syncs is high
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_pipe  <= 3'b111;
      vs_pipe  <= 3'b111;
      color_s1 <= 3'b000;
      color_s2 <= 3'b000;
    end else begin
      hs_pipe  <= {hs_pipe[1:0], vid.hsync};
      vs_pipe  <= {vs_pipe[1:0], vid.vsync};
      color_s1 <= vid.color;
      color_s2 <= color_s1;
    end
  end

  // Edge detection, raster position update and window decode
  always_comb begin
    hs_fall = hs_pipe[2] & ~hs_pipe[1];
    vs_fall = vs_pipe[2] & ~vs_pipe[1];

    // An HSync edge always starts a pixel period, whatever the free-running phase was.
    sample  = hs_fall | ~phase;

    // A correctly timed HSync lands exactly where pixel 0 would be sampled anyway.
    hs_slip = hs_fall & (phase | (pix != '0));

    pix_cur = hs_fall ? '0 : pix;

    line_inc = (line == LINE_MAX) ? line : line + LINE_BITS'(1);

    // A pixel wrap or a slipped HSync both start a new line; VSync overrides.
    line_next = line;
    if (phase && !hs_fall && (pix == PIX_LAST)) begin
      line_next = line_inc;
    end
    if (hs_slip) begin
      line_next = line_inc;
    end
    if (vs_fall) begin
      line_next = '0;
    end

    // The pixel counter free-runs so that lines without HSync stay aligned.
    if (hs_fall) begin
      pix_next = '0;
    end else if (phase) begin
      pix_next = (pix == PIX_LAST) ? '0 : pix + PIX_BITS'(1);
    end else begin
      pix_next = pix;
    end
    phase_next = hs_fall | ~phase;

    in_window = (pix_cur   >= X_FIRST) && (pix_cur   <= X_LAST) &&
                (line_next >= Y_FIRST) && (line_next <= Y_LAST);

    do_write = (state == S_FRAME) && sample && !hs_slip && in_window;

    row_off = WIN_BITS'(line_next - Y_FIRST);
    col_off = WIN_BITS'(pix_cur - X_FIRST);
  end

  // Capture FSM with counters and registered memory-write / status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      pix               <= '0;
      phase             <= 1'b0;
      line              <= '0;
      vid.write_enable  <= 1'b0;
      vid.write_address <= '0;
      vid.write_data    <= 3'b000;
      vid.frame_done    <= 1'b0;
      vid.locked        <= 1'b0;
      vid.error         <= 1'b0;
    end else begin
      pix   <= pix_next;
      phase <= phase_next;
      line  <= line_next;

      vid.write_enable <= do_write;
      if (do_write) begin
        vid.write_address <= {row_off, col_off};
        vid.write_data    <= color_s2;
      end

      vid.frame_done <= 1'b0;
      vid.error      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (vs_fall) begin
            state <= S_FRAME;
          end
        end
        S_FRAME: begin
          if (vs_fall) begin
            vid.frame_done <= 1'b1;
            if (line == LINES_FRAME) begin
              vid.locked <= 1'b1;
            end else begin
              vid.locked <= 1'b0;
              vid.error  <= 1'b1;
            end
          end
          // A slipped HSync loses lock even if the frame length was right.
          if (hs_slip) begin
            vid.locked <= 1'b0;
            vid.error  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_capture
// Purpose  : Self-checking bench for vga_frame_capture on a reduced raster
//            (24 x 20 pixels, 8 x 8 window, 6-bit line counter). A source
//            model drives pixels and predicts every strobe, pulse and lock
//            value from raster coordinates; a monitor compares each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_frame_capture;

  localparam int H_SYNC  = 4;
  localparam int H_BACK  = 2;
  localparam int H_TOTAL = 24;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 3;
  localparam int V_TOTAL = 20;
  localparam int WIN_X0  = 3;
  localparam int WIN_Y0  = 2;
  localparam int WB      = 3;
  localparam int LB      = 6;

  localparam int W    = 1 << WB;
  localparam int X0   = H_SYNC + H_BACK + WIN_X0;
  localparam int Y0   = V_SYNC + V_BACK + WIN_Y0;
  localparam int LMAX = (1 << LB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_frame_capture_if #(.WIN_BITS(WB)) vif ();

  vga_frame_capture #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_TOTAL(V_TOTAL),
    .WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0), .WIN_BITS(WB), .LINE_BITS(LB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vid (vif)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int addr; int data; } wr_t;
  typedef struct { int due; bit fd; bit err; bit lupd; bit lval; } ev_t;

  wr_t wq[$];
  ev_t eq[$];

  int n_cmp     = 0;
  int n_bad     = 0;
  int cyc       = 0;
  int n_strobes = 0;
  int last_addr = 0;
  int last_data = 0;
  bit exp_locked = 1'b0;

  // Source-side model state
  bit armed = 1'b0;   // capture block expected to be in frame mode
  int mline = 0;      // line index as the receiver should count it

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Per-cycle monitor, sampled 1 time unit after the active edge
  always @(posedge clk) begin
    bit exp_fd;
    bit exp_err;
    #1;
    cyc++;
    if (vif.write_enable === 1'b1) n_strobes++;
    if (wq.size() > 0 && wq[0].due == cyc) begin
      check_value("we", {31'd0, vif.write_enable}, 1);
      check_value("addr", {16'd0, vif.write_address}, wq[0].addr);
      check_value("data", {29'd0, vif.write_data}, wq[0].data);
      last_addr = wq[0].addr;
      last_data = wq[0].data;
      void'(wq.pop_front());
    end else begin
      check_value("we_idle", {31'd0, vif.write_enable}, 0);
      check_value("addr_hold", {16'd0, vif.write_address}, last_addr);
      check_value("data_hold", {29'd0, vif.write_data}, last_data);
    end
    exp_fd  = 1'b0;
    exp_err = 1'b0;
    if (eq.size() > 0 && eq[0].due == cyc) begin
      exp_fd  = eq[0].fd;
      exp_err = eq[0].err;
      if (eq[0].lupd) exp_locked = eq[0].lval;
      void'(eq.pop_front());
    end
    check_value("frame_done", {31'd0, vif.frame_done}, {31'd0, exp_fd});
    check_value("error", {31'd0, vif.error}, {31'd0, exp_err});
    check_value("locked", {31'd0, vif.locked}, {31'd0, exp_locked});
  end

  task automatic drive_pixel(input bit hs, input bit vs, input logic [2:0] col);
    vif.hsync = hs;
    vif.vsync = vs;
    vif.color = col;
    repeat (2) @(negedge clk);
  endtask

  // One source frame. gl/gp: line cut short at pixel gp (early HSync).
  // rl/rp: pixel at which reset is pulsed for 3 clocks. -1 disables.
  task automatic run_frame(input bit with_vs, input int gl, input int gp, input bit hot,
                           input bit omit_hs, input int rl, input int rp);
    for (int l = 0; l < V_TOTAL; l++) begin
      int len;
      len = (l == gl) ? gp : H_TOTAL;
      for (int p = 0; p < len; p++) begin
        bit         hs;
        bit         vs;
        bit         lok;
        logic [2:0] col;
        if (l == rl && p == rp) begin
          rst = 1'b1;
          wq.delete();
          eq.delete();
          armed      = 1'b0;
          last_addr  = 0;
          last_data  = 0;
          exp_locked = 1'b0;
          fork
            begin
              repeat (3) @(negedge clk);
              rst = 1'b0;
            end
          join_none
        end
        vs = !(with_vs && l < V_SYNC);
        hs = !(p < H_SYNC && (l == 0 || l >= V_SYNC + V_BACK || !omit_hs));
        if (p == 0 && l == 0 && with_vs) begin
          if (armed) begin
            lok = (mline == V_TOTAL);
            eq.push_back('{due: cyc + 3, fd: 1'b1, err: !lok, lupd: 1'b1, lval: lok});
          end
          armed = 1'b1;
          mline = 0;
        end
        if (p == 0 && l > 0 && (l - 1) == gl && armed) begin
          eq.push_back('{due: cyc + 3, fd: 1'b0, err: 1'b1, lupd: 1'b1, lval: 1'b0});
        end
        if (hot) col = (l == Y0 && p == X0) ? 3'd7 : 3'd0;
        else     col = 3'($urandom_range(0, 7));
        if (armed && mline >= Y0 && mline <= Y0 + W - 1 && p >= X0 && p <= X0 + W - 1) begin
          wq.push_back('{due: cyc + 3, addr: (mline - Y0) * W + (p - X0), data: int'(col)});
        end
        drive_pixel(hs, vs, col);
      end
      mline = (mline < LMAX) ? mline + 1 : LMAX;
    end
  endtask

  task automatic nominal_frame(input string tag, input bit omit_hs);
    int s0;
    s0 = n_strobes;
    run_frame(1'b1, -1, 0, 1'b0, omit_hs, -1, -1);
    check_value(tag, n_strobes - s0, W * W);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    vif.color = 3'd0;
    rst       = 1'b1;
    repeat (5) @(negedge clk);
    check_value("reset_locked", {31'd0, vif.locked}, 0);
    check_value("reset_addr", {16'd0, vif.write_address}, 0);
    rst = 1'b0;

    // Nominal frames, with and without HSync during vertical porch lines
    nominal_frame("strobes_frame1", 1'b0);
    nominal_frame("strobes_frame2", 1'b1);
    nominal_frame("strobes_frame3", 1'b0);
    check_value("locked_nominal", {31'd0, vif.locked}, 1);

    // Single hot pixel at window origin
    s0 = n_strobes;
    run_frame(1'b1, -1, 0, 1'b1, 1'b1, -1, -1);
    check_value("strobes_hot", n_strobes - s0, W * W);

    // Early HSync mid-window, then clean frames
    run_frame(1'b1, Y0 + 2, $urandom_range(X0 + 2, H_TOTAL - 2), 1'b0, 1'b0, -1, -1);
    check_value("locked_after_slip", {31'd0, vif.locked}, 0);
    run_frame(1'b1, -1, 0, 1'b0, 1'b1, -1, -1);
    check_value("locked_relock", {31'd0, vif.locked}, 1);

    // VSync withheld for three frames: line counter saturates, no stray writes
    nominal_frame("strobes_pre_withhold", 1'b0);
    s0 = n_strobes;
    repeat (3) run_frame(1'b0, -1, 0, 1'b0, 1'b0, -1, -1);
    check_value("strobes_withheld", n_strobes - s0, 0);
    nominal_frame("strobes_vs_return", 1'b1);
    check_value("locked_vs_return", {31'd0, vif.locked}, 0);
    nominal_frame("strobes_relock2", 1'b0);
    check_value("locked_relock2", {31'd0, vif.locked}, 1);

    // Reset inside the window; capture resumes only after the next VSync
    s0 = n_strobes;
    run_frame(1'b1, -1, 0, 1'b0, 1'b0, Y0 + 3, X0 + 4);
    check_value("locked_after_reset", {31'd0, vif.locked}, 0);
    nominal_frame("strobes_resume", 1'b1);
    check_value("locked_first_after_reset", {31'd0, vif.locked}, 0);
    nominal_frame("strobes_resume2", 1'b0);
    check_value("locked_resumed", {31'd0, vif.locked}, 1);

    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    repeat (10) @(negedge clk);
    check_value("wr_pending", wq.size(), 0);
    check_value("ev_pending", eq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
